subxor_arbiter: RTL and testbench
=================================

SUBXOR_ARBITER -- requirements
Module: subxor_arbiter

Interface
REQ-001 SHALL have parameter LAT, default 2, meaning fixed cycles from dp_* issue to matching dp_z_i (range 1..8).
REQ-002 SHALL have parameter DEPTH, default 4, meaning result FIFO entries (power of two, 2..16).
REQ-003 SHALL have port clk_i, input, 1, the single clock; all state on rising edge.
REQ-004 SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port req_valid_i, input, 2, per-requester request valid.
REQ-006 SHALL have port req_ready_o, output, 2, per-requester grant (accept) strobe.
REQ-007 SHALL have ports req_x_i / req_y_i / req_ex_i, input, 2 x prng_t each, per-requester operands.
REQ-008 SHALL have ports req_mode_i, input, 2 x mode_t, and req_width_i, input, 2 x width_t, per-requester op and lane width.
REQ-009 SHALL have ports dp_x_o / dp_y_o / dp_ex_o, output, prng_t each, registered operands to the sub/xor datapath.
REQ-010 SHALL have ports dp_mode_o, output, mode_t, and dp_width_o, output, width_t, registered datapath controls.
REQ-011 SHALL have port dp_z_i, input, prng_t, datapath result.
REQ-012 SHALL have ports res_valid_o, output, 1, and res_ready_i, input, 1, result handshake.
REQ-013 SHALL have ports res_z_o, output, prng_t, and res_id_o, output, 1, result data and originating requester.
REQ-014 SHALL have port busy_o, output, 1, high while any op is in flight or queued.

Function
REQ-015 SHALL accept a request when req_valid_i[k] & req_ready_o[k]; at most one bit of req_ready_o high per cycle.
REQ-016 SHALL assert req_ready_o only when inflight_count + fifo_count < DEPTH (current-cycle values; same-cycle pop not credited).
REQ-017 SHALL arbitrate round-robin: with both valid, grant the requester not granted last; with one valid, grant it; pointer updates only on a grant.
REQ-018 SHALL register the granted operands/controls onto dp_* in the grant cycle+1; dp_* hold their previous value when no grant.
REQ-019 SHALL track each issue in a LAT-stage valid/id shift register and push {dp_z_i, id} into the FIFO exactly LAT cycles after the dp_* update.
REQ-020 SHALL present FIFO head on res_z_o/res_id_o with res_valid_o = FIFO non-empty; pop on res_valid_o & res_ready_i.
REQ-021 SHALL preserve issue order for results; simultaneous push and pop on a full or empty FIFO SHALL both succeed without loss.
REQ-022 SHALL never overflow the FIFO: the credit rule in REQ-016 guarantees space for every in-flight op.
REQ-023 SHALL hold req_ready_o low regardless of req_valid_i when credits are exhausted; requesters are not required to hold valid.

Reset
REQ-024 SHALL on rst_i drive req_ready_o=0, res_valid_o=0, res_z_o=0, res_id_o=0, busy_o=0, all dp_*=0, RR pointer to requester 0.
REQ-025 SHALL on reset mid-operation discard all in-flight and queued results; dp_z_i arriving after reset release for pre-reset issues SHALL be ignored.

Configuration
REQ-026 SHALL compile with SUBXOR_ARB_STATS_EN defined: two 32-bit saturating grant counters (grant_cnt0_o, grant_cnt1_o) and a 32-bit stall counter (cycles with any req_valid_i but no grant), cleared by rst_i.
REQ-027 SHALL without SUBXOR_ARB_STATS_EN omit counters and their ports entirely; all other behaviour identical.

Structure
REQ-028 SHALL take prng_t, mode_t, width_t from package TYPES; add req_id_t (1 bit) and subxor_req_t struct {x, y, ex, mode, width} to TYPES.
REQ-029 SHALL implement the result buffer as sub-module subxor_res_fifo (DEPTH, {prng_t, req_id_t}, count output).

Verification (bench models the datapath as a LAT-cycle delay of z = x - y for mode sub, x ^ y for xor)
REQ-030 Single req0 x=5,y=3,sub,res_ready_i=1 -> res_valid_o exactly 1+LAT+1 cycles after grant, res_z_o=2, res_id_o=0.
REQ-031 Both requesters valid continuously, 8 ops each -> grants alternate 0,1,0,1...; results in same order.
REQ-032 res_ready_i=0, LAT=2, DEPTH=4 -> exactly 4 grants then req_ready_o=0; raise res_ready_i -> one new grant per pop.
REQ-033 Full FIFO with res_ready_i=1 and concurrent arrival -> no drop, no duplicate, count stays 4.
REQ-034 rst_i pulsed with 3 ops in flight -> all outputs at reset values next cycle; no stale result emitted afterwards.
REQ-035 SUBXOR_ARB_STATS_EN defined, 5 req0 + 3 req1 grants -> grant_cnt0_o=5, grant_cnt1_o=3.

Source files
------------

// File: rtl/subxor_arbiter_pkg.sv
// Shared types for the sub/xor request arbiter: operand, control, request
// and result-entry types plus the two-way round-robin pick helper.
package TYPES;

    localparam int PRNG_W = 16;

    typedef logic [PRNG_W-1:0] prng_t;

    typedef enum logic {
        MODE_SUB = 1'b0,
        MODE_XOR = 1'b1
    } mode_t;

    typedef logic [1:0] width_t;

    typedef logic req_id_t;

    typedef struct packed {
        prng_t  x;
        prng_t  y;
        prng_t  ex;
        mode_t  mode;
        width_t width;
    } subxor_req_t;

    typedef struct packed {
        prng_t   z;
        req_id_t id;
    } subxor_res_t;

    // Returns {grant_valid, grant_id}. With both requesters valid the one
    // named by ptr wins; ptr always names the requester not granted last.
    function automatic logic [1:0] rr_pick(input logic [1:0] valid, input logic ptr);
        logic [1:0] r;
        case (valid)
            2'b01:   r = 2'b10;
            2'b10:   r = 2'b11;
            2'b11:   r = {1'b1, ptr};
            default: r = 2'b00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/subxor_arbiter_res_fifo.sv
// subxor_res_fifo: power-of-two result FIFO holding {z, id} entries.
// Push and pop may happen in the same cycle, including when full (the pop
// frees the slot the push lands in) or empty (only the push takes effect).
module subxor_res_fifo
    import TYPES::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    push_i,
    input  subxor_res_t             push_data_i,
    input  logic                    pop_i,
    output subxor_res_t             head_o,
    output logic                    empty_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    subxor_res_t     mem_q [DEPTH];
    subxor_res_t     mem_d [DEPTH];
    logic [AW-1:0]   wr_q, wr_d;
    logic [AW-1:0]   rd_q, rd_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_push;
    logic            do_pop;

    // Pointer/count update; a push into a full FIFO is only taken with a pop.
    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        do_pop  = pop_i && (count_q != '0);
        do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);
        if (do_push) begin
            mem_d[wr_q] = push_data_i;
            wr_d        = wr_q + AW'(1);
        end
        if (do_pop) begin
            rd_d = rd_q + AW'(1);
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    // Storage and pointer registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    assign head_o  = mem_q[rd_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/subxor_arbiter.sv
// subxor_arbiter: two-requester round-robin front end for a fixed-latency
// sub/xor datapath. Grants are credit limited so every issued op already
// owns a result FIFO slot. Optional statistics counters are built when
// SUBXOR_ARB_STATS_EN is defined.
module subxor_arbiter
    import TYPES::*;
#(
    parameter int LAT   = 2,
    parameter int DEPTH = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [1:0]        req_valid_i,
    output logic [1:0]        req_ready_o,
    input  prng_t [1:0]       req_x_i,
    input  prng_t [1:0]       req_y_i,
    input  prng_t [1:0]       req_ex_i,
    input  mode_t [1:0]       req_mode_i,
    input  width_t [1:0]      req_width_i,
    output prng_t             dp_x_o,
    output prng_t             dp_y_o,
    output prng_t             dp_ex_o,
    output mode_t             dp_mode_o,
    output width_t            dp_width_o,
    input  prng_t             dp_z_i,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output prng_t             res_z_o,
    output req_id_t           res_id_o,
    output logic              busy_o
`ifdef SUBXOR_ARB_STATS_EN
    ,
    output logic [31:0]       grant_cnt0_o,
    output logic [31:0]       grant_cnt1_o,
    output logic [31:0]       stall_cnt_o
`endif
);

    localparam int FCW = $clog2(DEPTH) + 1;

    logic            ptr_q, ptr_d;
    subxor_req_t     dp_q, dp_d;
    logic            issue_q, issue_d;
    req_id_t         issue_id_q, issue_id_d;
    logic [LAT-1:0]  vld_q, vld_d;
    logic [LAT-1:0]  id_q, id_d;

    logic [FCW-1:0]  fifo_count;
    logic            fifo_empty;
    subxor_res_t     fifo_head;
    subxor_res_t     push_data;
    logic            push;
    logic            pop;

    logic [4:0]      inflight;
    logic [5:0]      occupancy;
    logic            credit_ok;
    logic            gnt_vld;
    req_id_t         gnt_id;
    logic [1:0]      pick;

    // Ops in flight (issue register plus latency pipe) and credit check.
    // A pop in this cycle is not credited until the next one.
    always_comb begin
        inflight = 5'(issue_q);
        for (int i = 0; i < LAT; i++) begin
            inflight = inflight + 5'(vld_q[i]);
        end
        occupancy = {1'b0, inflight} + 6'(fifo_count);
        credit_ok = (occupancy < 6'(DEPTH));
    end

    // Round-robin grant; ready is held low in reset and without credit.
    always_comb begin
        pick        = rr_pick(req_valid_i, ptr_q);
        gnt_vld     = pick[1] && credit_ok && !rst_i;
        gnt_id      = pick[0];
        req_ready_o = gnt_vld ? (2'b01 << gnt_id) : 2'b00;
        ptr_d       = ptr_q;
        if (gnt_vld) begin
            ptr_d = ~gnt_id;
        end
    end

    // Capture granted operands for the datapath; hold otherwise.
    always_comb begin
        dp_d       = dp_q;
        issue_d    = gnt_vld;
        issue_id_d = gnt_id;
        if (gnt_vld) begin
            dp_d.x     = req_x_i[gnt_id];
            dp_d.y     = req_y_i[gnt_id];
            dp_d.ex    = req_ex_i[gnt_id];
            dp_d.mode  = req_mode_i[gnt_id];
            dp_d.width = req_width_i[gnt_id];
        end
    end

    // Latency pipe: the last stage lines up with dp_z_i for that issue.
    always_comb begin
        vld_d[0] = issue_q;
        id_d[0]  = issue_id_q;
        for (int i = 1; i < LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            id_d[i]  = id_q[i-1];
        end
    end

    // Arbiter, datapath-operand and pipe registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q      <= 1'b0;
            dp_q       <= '0;
            issue_q    <= 1'b0;
            issue_id_q <= 1'b0;
            vld_q      <= '0;
            id_q       <= '0;
        end else begin
            ptr_q      <= ptr_d;
            dp_q       <= dp_d;
            issue_q    <= issue_d;
            issue_id_q <= issue_id_d;
            vld_q      <= vld_d;
            id_q       <= id_d;
        end
    end

    assign push         = vld_q[LAT-1];
    assign push_data.z  = dp_z_i;
    assign push_data.id = id_q[LAT-1];
    assign pop          = res_valid_o && res_ready_i;

    subxor_res_fifo #(
        .DEPTH (DEPTH)
    ) u_res_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign dp_x_o      = dp_q.x;
    assign dp_y_o      = dp_q.y;
    assign dp_ex_o     = dp_q.ex;
    assign dp_mode_o   = dp_q.mode;
    assign dp_width_o  = dp_q.width;

    assign res_valid_o = !fifo_empty;
    assign res_z_o     = res_valid_o ? fifo_head.z  : '0;
    assign res_id_o    = res_valid_o ? fifo_head.id : 1'b0;
    assign busy_o      = (occupancy != '0);

`ifdef SUBXOR_ARB_STATS_EN
    logic [31:0] gcnt0_q, gcnt0_d;
    logic [31:0] gcnt1_q, gcnt1_d;
    logic [31:0] stall_q, stall_d;

    // Saturating grant and stall counters.
    always_comb begin
        gcnt0_d = gcnt0_q;
        gcnt1_d = gcnt1_q;
        stall_d = stall_q;
        if (gnt_vld && !gnt_id && (gcnt0_q != '1)) gcnt0_d = gcnt0_q + 32'd1;
        if (gnt_vld &&  gnt_id && (gcnt1_q != '1)) gcnt1_d = gcnt1_q + 32'd1;
        if ((|req_valid_i) && !gnt_vld && (stall_q != '1)) stall_d = stall_q + 32'd1;
    end

    // Counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            gcnt0_q <= '0;
            gcnt1_q <= '0;
            stall_q <= '0;
        end else begin
            gcnt0_q <= gcnt0_d;
            gcnt1_q <= gcnt1_d;
            stall_q <= stall_d;
        end
    end

    assign grant_cnt0_o = gcnt0_q;
    assign grant_cnt1_o = gcnt1_q;
    assign stall_cnt_o  = stall_q;
`endif

endmodule

// File: tb/tb_subxor_arbiter.sv
// Bench for subxor_arbiter: datapath modelled as a LAT-cycle delay of
// x-y / x^y, a scoreboard of expected results filled at each grant, a
// vector table for single ops and directed multi-cycle sequences.
module tb_subxor_arbiter;
    import TYPES::*;

    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    prng_t [1:0]   req_x, req_y, req_ex;
    mode_t [1:0]   req_mode;
    width_t [1:0]  req_width;
    prng_t         dp_x, dp_y, dp_ex, dp_z;
    mode_t         dp_mode;
    width_t        dp_width;
    logic          res_valid, res_ready;
    prng_t         res_z;
    req_id_t       res_id;
    logic          busy;
`ifdef SUBXOR_ARB_STATS_EN
    logic [31:0]   gc0, gc1, sc;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    subxor_arbiter #(.LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_x_i     (req_x),
        .req_y_i     (req_y),
        .req_ex_i    (req_ex),
        .req_mode_i  (req_mode),
        .req_width_i (req_width),
        .dp_x_o      (dp_x),
        .dp_y_o      (dp_y),
        .dp_ex_o     (dp_ex),
        .dp_mode_o   (dp_mode),
        .dp_width_o  (dp_width),
        .dp_z_i      (dp_z),
        .res_valid_o (res_valid),
        .res_ready_i (res_ready),
        .res_z_o     (res_z),
        .res_id_o    (res_id),
        .busy_o      (busy)
`ifdef SUBXOR_ARB_STATS_EN
        ,
        .grant_cnt0_o (gc0),
        .grant_cnt1_o (gc1),
        .stall_cnt_o  (sc)
`endif
    );

    // Datapath model: z follows dp_* by LAT cycles.
    prng_t zq [LAT];
    always @(posedge clk) begin
        zq[0] <= (dp_mode == MODE_SUB) ? prng_t'(dp_x - dp_y) : prng_t'(dp_x ^ dp_y);
        for (int i = 1; i < LAT; i++) zq[i] <= zq[i-1];
    end
    assign dp_z = zq[LAT-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic prng_t model_z(input mode_t m, input prng_t x, input prng_t y);
        return (m == MODE_SUB) ? prng_t'(x - y) : prng_t'(x ^ y);
    endfunction

    // Scoreboard: expected entries pushed at grant, compared at pop.
    subxor_res_t sb[$];
    int          grant_log[$];
    int          grants  = 0;
    int          pops    = 0;
    int          max_out = 0;
    always @(negedge clk) begin
        subxor_res_t e;
        if (rst) begin
            sb.delete();
        end else begin
            chk("ready_onehot", 32'($onehot0(req_ready)), 32'd1);
            if (res_valid && res_ready) begin
                pops++;
                if (sb.size() == 0) begin
                    chk("stale_result", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("res_z", 32'(res_z), 32'(e.z));
                    chk("res_id", 32'(res_id), 32'(e.id));
                end
            end
            for (int k = 0; k < 2; k++) begin
                if (req_valid[k] && req_ready[k]) begin
                    e.z  = model_z(req_mode[k], req_x[k], req_y[k]);
                    e.id = req_id_t'(k);
                    sb.push_back(e);
                    grant_log.push_back(k);
                    grants++;
                end
            end
            if (sb.size() > max_out) max_out = sb.size();
        end
    end

    task automatic drain(input string name);
        int n = 0;
        res_ready = 1'b1;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        tick();
        chk(name, 32'(busy), 32'd0);
        chk({name, "_sb"}, 32'(sb.size()), 32'd0);
    endtask

    typedef struct {
        int    id;
        mode_t mode;
        prng_t x;
        prng_t y;
        prng_t z;
    } vec_t;

    vec_t vt [6];

    initial begin
        int n, g0, p0, c0, c1, guard, v;

        vt[0] = '{0, MODE_SUB, 16'd5,    16'd3,    16'd2};
        vt[1] = '{1, MODE_XOR, 16'hF0F0, 16'h0FF0, 16'hFF00};
        vt[2] = '{0, MODE_SUB, 16'd3,    16'd5,    16'hFFFE};
        vt[3] = '{0, MODE_XOR, 16'hFFFF, 16'hFFFF, 16'h0000};
        vt[4] = '{1, MODE_SUB, 16'h8000, 16'h0001, 16'h7FFF};
        vt[5] = '{1, MODE_XOR, 16'h1234, 16'h0000, 16'h1234};

        req_valid = 2'b11;
        res_ready = 1'b1;
        req_x     = '0;
        req_y     = '0;
        req_ex    = '0;
        req_width = '0;
        req_mode[0] = MODE_SUB;
        req_mode[1] = MODE_SUB;

        // Reset state, with both requesters asserting valid.
        repeat (2) tick();
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_z", 32'(res_z), 32'd0);
        chk("rst_res_id", 32'(res_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dp", {dp_x, dp_y}, 32'd0);
        chk("rst_dp_ctl", {dp_ex, 13'd0, dp_mode, dp_width}, 32'd0);
        req_valid = 2'b00;
        rst = 1'b0;
        tick();

        // Single ops from the table: grant, dp capture, latency, result.
        for (int i = 0; i < 6; i++) begin
            req_x[vt[i].id]     = vt[i].x;
            req_y[vt[i].id]     = vt[i].y;
            req_mode[vt[i].id]  = vt[i].mode;
            req_ex[vt[i].id]    = prng_t'(16'h00A5 + i);
            req_width[vt[i].id] = width_t'(i);
            req_valid = 2'b01 << vt[i].id;
            #1;
            chk("vec_ready", 32'(req_ready), 32'(2'b01 << vt[i].id));
            tick();
            req_valid = 2'b00;
            chk("vec_dp_x", 32'(dp_x), 32'(vt[i].x));
            chk("vec_dp_ctl", {dp_ex, 13'd0, dp_mode, dp_width},
                {prng_t'(16'h00A5 + i), 13'd0, vt[i].mode, width_t'(i)});
            n = 1;
            while (!res_valid && n < 20) begin
                tick();
                n++;
            end
            chk("vec_latency", 32'(n), 32'(LAT + 2));
            chk("vec_z", 32'(res_z), 32'(vt[i].z));
            chk("vec_id", 32'(res_id), 32'(vt[i].id));
            tick();
        end
        drain("vec_drain");

        // Both requesters continuously valid: grants alternate 0,1,0,1.
        grant_log.delete();
        req_mode[0] = MODE_SUB;
        req_mode[1] = MODE_XOR;
        c0 = 0; c1 = 0; guard = 0;
        while ((c0 < 8 || c1 < 8) && guard < 300) begin
            req_valid = {c1 < 8, c0 < 8};
            req_x[0] = prng_t'(100 + c0 * 3);
            req_y[0] = prng_t'(c0);
            req_x[1] = 16'h5A00 | prng_t'(c1);
            req_y[1] = 16'h00FF;
            #1;
            if (req_ready[0]) c0++;
            if (req_ready[1]) c1++;
            tick();
            guard++;
        end
        req_valid = 2'b00;
        chk("rr_count", 32'(grant_log.size()), 32'd16);
        for (int i = 0; i < grant_log.size(); i++) begin
            chk("rr_order", 32'(grant_log[i]), 32'(i % 2));
        end
        drain("rr_drain");

        // Credits: result sink stalled, exactly DEPTH grants then ready low.
        res_ready = 1'b0;
        req_mode[0] = MODE_SUB;
        req_x[0] = 16'd40;
        req_y[0] = 16'd1;
        req_valid = 2'b01;
        g0 = grants;
        repeat (15) tick();
        chk("credit_grants", 32'(grants - g0), 32'(DEPTH));
        chk("credit_ready_low", 32'(req_ready), 32'd0);
        chk("credit_busy", 32'(busy), 32'd1);
        for (int r = 0; r < 2; r++) begin
            req_x[0] = prng_t'(16'd50 + r);
            res_ready = 1'b1;
            g0 = grants;
            tick();
            res_ready = 1'b0;
            repeat (10) tick();
            chk("pop_regrant", 32'(grants - g0), 32'd1);
        end

        // Full FIFO draining while new results keep arriving.
        res_ready = 1'b1;
        p0 = pops;
        for (int i = 0; i < 20; i++) begin
            req_x[0] = prng_t'(i * 7 + 3);
            req_y[0] = prng_t'(i);
            tick();
        end
        req_valid = 2'b00;
        chk("full_flow_pops", 32'(pops - p0 >= 12), 32'd1);
        drain("full_drain");
        chk("max_outstanding", 32'(max_out), 32'(DEPTH));
        chk("grants_eq_pops", 32'(grants), 32'(pops));

        // Reset pulse with three ops in flight.
        res_ready = 1'b0;
        req_valid = 2'b11;
        repeat (3) tick();
        req_valid = 2'b01;
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        chk("mid_rst_res_valid", 32'(res_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_dp", {dp_x, dp_y}, 32'd0);
        tick();
        rst = 1'b0;
        req_valid = 2'b00;
        res_ready = 1'b1;
        v = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (res_valid) v++;
        end
        chk("post_rst_no_result", 32'(v), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);

`ifdef SUBXOR_ARB_STATS_EN
        // Five req0 grants then three req1 grants.
        for (int i = 0; i < 8; i++) begin
            req_valid = (i < 5) ? 2'b01 : 2'b10;
            tick();
            req_valid = 2'b00;
            tick();
        end
        drain("stats_drain");
        chk("grant_cnt0", gc0, 32'd5);
        chk("grant_cnt1", gc1, 32'd3);
        chk("stall_cnt", sc, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
